// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
//   Captures capture_len beats from each channel selected by chan_mask,
//   lowest channel first, and serialises them onto one AXI4-Stream master.
//   ADC inputs cannot stall: a beat that arrives while the output slot is
//   occupied is dropped and flagged through the sticky overflow output.
//
//   Optional feature macro: ADC_CAPTURE_HEADER_EN
//     When defined, each channel block starts with a header beat
//     {64-bit free-running aclk count, channel index, capture_len}.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_tdata/tvalid    NCHAN packed ADC streams (no tready)
//   start, chan_mask,
//   capture_len            capture command, sampled while idle
//   m_axis_tdata/tvalid/
//   tready/tuser/tlast     serialised output stream, tuser = channel index
//   busy                   high outside IDLE
//   done                   one-cycle pulse when a capture completes
//   overflow               sticky dropped-beat flag for the current capture
//   cmd_err                one-cycle pulse on a rejected start
module adc_capture_sequencer #(
  parameter int unsigned NCHAN      = 8,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned LEN_WIDTH  = 12,
  localparam int unsigned CHAN_W    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NCHAN*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NCHAN-1:0]            s_axis_tvalid,
  input  logic                        start,
  input  logic [NCHAN-1:0]            chan_mask,
  input  logic [LEN_WIDTH-1:0]        capture_len,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [CHAN_W-1:0]           m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic                        cmd_err
);

  typedef enum logic [1:0] {IDLE, SELECT, CAPTURE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [NCHAN-1:0]       rem_mask_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_cnt_q;
  logic [CHAN_W-1:0]      ch_q;
  logic [CHAN_W-1:0]      sel_idx_c;
  logic [NCHAN-1:0]       ch_bit_c;
  logic                   slot_free_c;
  logic                   start_ok_c;
  logic                   start_bad_c;
  logic                   accept_c;
  logic                   drop_c;
  logic                   last_c;
  logic                   drain_done_c;
`ifdef ADC_CAPTURE_HEADER_EN
  logic [63:0]            ts_q;
  logic                   hdr_pend_q;
  logic                   hdr_send_c;
`endif

  // Output register can take a new beat when empty or being emptied now.
  assign slot_free_c = !m_axis_tvalid || m_axis_tready;
  assign ch_bit_c    = NCHAN'(1) << ch_q;

  // Lowest set bit of the remaining mask.
  always_comb begin
    sel_idx_c = '0;
    for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
      if (rem_mask_q[i]) sel_idx_c = CHAN_W'(i);
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d      = state_q;
    start_ok_c   = 1'b0;
    start_bad_c  = 1'b0;
    accept_c     = 1'b0;
    drop_c       = 1'b0;
    last_c       = 1'b0;
    drain_done_c = 1'b0;
`ifdef ADC_CAPTURE_HEADER_EN
    hdr_send_c   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (chan_mask != '0 && capture_len != '0) begin
            start_ok_c = 1'b1;
            state_d    = SELECT;
          end else begin
            start_bad_c = 1'b1;
          end
        end
      end
      SELECT: state_d = CAPTURE;
      CAPTURE: begin
`ifdef ADC_CAPTURE_HEADER_EN
        // ADC beats arriving while the header waits are not captured.
        if (hdr_pend_q) hdr_send_c = slot_free_c;
        else
`endif
        if (s_axis_tvalid[ch_q]) begin
          if (slot_free_c) begin
            accept_c = 1'b1;
            if (beat_cnt_q == len_q - LEN_WIDTH'(1)) begin
              last_c  = 1'b1;
              state_d = ((rem_mask_q & ~ch_bit_c) != '0) ? SELECT : DRAIN;
            end
          end else begin
            drop_c = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (slot_free_c) begin
          drain_done_c = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ADC_CAPTURE_HEADER_EN
  // Free-running timestamp for header beats.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ts_q <= '0;
    else          ts_q <= ts_q + 64'd1;
  end
`endif

  // Command latches, counters, status and the output beat register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rem_mask_q    <= '0;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      ch_q          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      cmd_err       <= 1'b0;
`ifdef ADC_CAPTURE_HEADER_EN
      hdr_pend_q    <= 1'b0;
`endif
    end else begin
      busy    <= (state_d != IDLE);
      done    <= drain_done_c;
      cmd_err <= start_bad_c;

      if (start_ok_c) begin
        rem_mask_q <= chan_mask;
        len_q      <= capture_len;
        overflow   <= 1'b0;
      end
      if (drop_c) overflow <= 1'b1;

      if (state_q == SELECT) begin
        ch_q       <= sel_idx_c;
        beat_cnt_q <= '0;
`ifdef ADC_CAPTURE_HEADER_EN
        hdr_pend_q <= 1'b1;
`endif
      end

      if (accept_c) begin
        beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
        if (last_c) rem_mask_q <= rem_mask_q & ~ch_bit_c;
      end

      // Load only when the slot is free so a stalled beat stays stable.
`ifdef ADC_CAPTURE_HEADER_EN
      if (hdr_send_c) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= DATA_WIDTH'({ts_q, ch_q, len_q});
        m_axis_tuser  <= ch_q;
        m_axis_tlast  <= 1'b0;
        hdr_pend_q    <= 1'b0;
      end else
`endif
      if (accept_c) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata[32'(ch_q) * DATA_WIDTH +: DATA_WIDTH];
        m_axis_tuser  <= ch_q;
        m_axis_tlast  <= last_c;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adc_capture_sequencer.md
ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 Parameter NCHAN, default 8, number of ADC AXI4-Stream inputs.
REQ-002 Parameter DATA_WIDTH, default 128, beat width per channel.
REQ-003 Parameter LEN_WIDTH, default 12, width of capture length.
REQ-004 aclk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 aresetn  input  1  asynchronous, active-low reset.
REQ-006 s_axis_tdata  input  NCHAN*DATA_WIDTH  channel n at bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_axis_tvalid  input  NCHAN  per-channel valid; no tready (ADC streams cannot stall).
REQ-008 start  input  1  single-cycle capture request.
REQ-009 chan_mask  input  NCHAN  channels to capture, sampled with start.
REQ-010 capture_len  input  LEN_WIDTH  beats per channel, sampled with start.
REQ-011 m_axis_tdata  output  DATA_WIDTH  captured beat.
REQ-012 m_axis_tvalid  output  1  output beat valid.
REQ-013 m_axis_tready  input  1  downstream ready.
REQ-014 m_axis_tuser  output  clog2(NCHAN)  channel index of current beat.
REQ-015 m_axis_tlast  output  1  last beat of a channel block.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse at capture completion.
REQ-018 overflow  output  1  sticky: an ADC beat was dropped during the capture.
REQ-019 cmd_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-020 States SHALL be IDLE, SELECT, CAPTURE, DRAIN.
REQ-021 IDLE: start with chan_mask!=0 and capture_len!=0 latches both, clears overflow, goes SELECT next cycle.
REQ-022 IDLE: start with chan_mask==0 or capture_len==0 SHALL pulse cmd_err the next cycle and stay IDLE.
REQ-023 start outside IDLE SHALL be ignored (no cmd_err, no effect).
REQ-024 SELECT: picks lowest set bit of remaining mask as current channel, clears beat counter, goes CAPTURE; exactly one cycle.
REQ-025 CAPTURE: a beat is accepted when s_axis_tvalid[ch]=1 and output slot free (m_axis_tvalid=0 or m_axis_tready=1); accepted beat appears on m_axis_* the next cycle.
REQ-026 CAPTURE: s_axis_tvalid[ch]=1 with slot not free SHALL drop the beat, set overflow, not advance the counter.
REQ-027 Beat counter SHALL count accepted beats; beat number capture_len-1 carries tlast=1, clears channel's mask bit.
REQ-028 After last beat: remaining mask nonzero -> SELECT; zero -> DRAIN.
REQ-029 DRAIN: when output empty (m_axis_tvalid=0, or tvalid&tready this cycle), done pulses next cycle and state returns IDLE.
REQ-030 m_axis_tvalid SHALL hold with tdata/tuser/tlast stable until tready (AXI4-Stream rules).
REQ-031 Inputs of unselected channels SHALL be ignored; overflow is sticky until next accepted start or reset.
REQ-032 Minimum start-to-first-output latency: 3 cycles (IDLE->SELECT->CAPTURE accept->output).

Reset
REQ-033 aresetn low SHALL immediately force IDLE, m_axis_tvalid=0, tlast=0, tuser=0, tdata=0, busy=0, done=0, overflow=0, cmd_err=0, counters and latched mask/len=0.
REQ-034 Reset mid-capture SHALL abandon the capture; no done pulse after release.
REQ-035 First start SHALL be honoured on the first aclk edge after aresetn deasserts.

Configuration
REQ-036 Macro ADC_CAPTURE_HEADER_EN defined: in SELECT->CAPTURE each channel block SHALL begin with one header beat {free-running 64-bit aclk counter, channel index, capture_len} zero-padded to DATA_WIDTH, tlast=0, tuser=channel; header waits for a free slot and never sets overflow; data beats follow.
REQ-037 Macro undefined: no header beat, no 64-bit counter logic; blocks contain exactly capture_len beats.

Verification
REQ-038 mask=8'h05, len=4, tvalid all 1, tready=1 -> 4 beats tuser=0 then 4 beats tuser=2, tlast on beats 4 and 8, done once, overflow=0.
REQ-039 mask=8'h80, len=16, tready low cycles 5-9 -> overflow=1, exactly 16 beats still delivered, tlast on 16th.
REQ-040 start with mask=0 (then len=0, mask=1) -> cmd_err pulse each time, busy stays 0, no output.
REQ-041 aresetn low during CAPTURE of mask=8'hFF, len=100 -> outputs zero immediately, no done; new start mask=1,len=2 completes normally.
REQ-042 start asserted while busy -> ignored; latched mask/len unchanged, output count matches original command.
REQ-043 ADC_CAPTURE_HEADER_EN defined, mask=8'h03, len=2 -> 6 beats: header,d,d(tlast),header,d,d(tlast); header channel fields 0 then 1, timestamps increasing.
